// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register bank and its address decoder.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_READ_WAIT     = 3'd1,
        ST_READ_VALID    = 3'd2,
        ST_WRITE_ACK     = 3'd3,
        ST_WRITE_RELEASE = 3'd4
    } bank_state_e;

    localparam logic [7:0] REG_READ_OOR   = 8'hFF;
    localparam logic [7:0] ADDR_DEVICE_ID = 8'h00;

    // Read latency counter width; covers READ_LATENCY up to 15.
    localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/i2c_reg_decode.sv
// Combinational address classifier: ID, control, status or out-of-range,
// plus the status byte index for status addresses.
module i2c_reg_decode
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned NUM_STATUS = 4,
    parameter int unsigned SIDX_W     = 2
) (
    input  logic [7:0]        addr,
    output logic              is_id,
    output logic              is_ctrl,
    output logic              is_status,
    output logic              out_of_range,
    output logic [SIDX_W-1:0] status_index
);

    localparam int unsigned STATUS_BASE = NUM_REGS - NUM_STATUS;

    logic [31:0] addr_ext;
    assign addr_ext = 32'(addr);

    // Full 8-bit compare: nothing above NUM_REGS-1 aliases back into the map.
    always_comb begin
        out_of_range = (addr_ext >= NUM_REGS);
        is_id        = (addr == ADDR_DEVICE_ID);
        is_status    = !out_of_range && !is_id && (addr_ext >= STATUS_BASE);
        is_ctrl      = !out_of_range && !is_id && !is_status;
        status_index = SIDX_W'(addr_ext - STATUS_BASE);
    end

endmodule

// File: rtl/i2c_register_bank.sv
// Byte-wide register bank behind the I2C peripheral: read/write handshakes,
// fabric-visible control registers and snapshotted read-only status inputs.
module i2c_register_bank
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned NUM_STATUS   = 4,
    parameter logic [7:0]  DEVICE_ID    = 8'hA5,
    parameter logic [7:0]  CTRL_RESET   = 8'h00,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    i_sys_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_register_address,
    input  logic                    i_read_enable,
    output logic [7:0]              o_register_data,
    output logic                    o_read_valid,
    input  logic                    i_read_ack,
    input  logic [7:0]              i_register_data,
    input  logic                    i_write_valid,
    output logic                    o_write_ack,
    output logic [8*NUM_REGS-1:0]   o_ctrl_regs,
    input  logic [8*NUM_STATUS-1:0] i_status_regs,
    output logic                    o_reg_written,
    output logic [7:0]              o_reg_written_addr
);

    localparam int unsigned IDX_W       = $clog2(NUM_REGS);
    localparam int unsigned SIDX_W      = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;
    localparam int unsigned STATUS_BASE = NUM_REGS - NUM_STATUS;

    bank_state_e      state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       status_q [NUM_STATUS];

    logic             snap_en, wr_en;
    logic [7:0]       rdata_d, waddr_d, rd_mux;
    logic             rvalid_d, wack_d, written_d;

    logic              is_id, is_ctrl, is_status, out_of_range;
    logic [SIDX_W-1:0] status_index;

    i2c_reg_decode #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS),
        .SIDX_W     (SIDX_W)
    ) u_decode (
        .addr         (addr_q),
        .is_id        (is_id),
        .is_ctrl      (is_ctrl),
        .is_status    (is_status),
        .out_of_range (out_of_range),
        .status_index (status_index)
    );

    // Read data mux on the latched address.
    always_comb begin
        rd_mux = REG_READ_OOR;
        if (out_of_range)   rd_mux = REG_READ_OOR;
        else if (is_id)     rd_mux = DEVICE_ID;
        else if (is_status) rd_mux = status_q[status_index];
        else                rd_mux = regs_q[IDX_W'(addr_q)];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        snap_en   = 1'b0;
        wr_en     = 1'b0;
        rdata_d   = o_register_data;
        rvalid_d  = o_read_valid;
        wack_d    = 1'b0;
        written_d = 1'b0;
        waddr_d   = o_reg_written_addr;
        case (state_q)
            ST_IDLE: begin
                if (i_read_enable) begin
                    addr_d  = i_register_address;
                    snap_en = 1'b1;
                    lat_d   = LAT_W'(READ_LATENCY - 1);
                    state_d = ST_READ_WAIT;
                end else if (i_write_valid) begin
                    addr_d  = i_register_address;
                    wack_d  = 1'b1;
                    state_d = ST_WRITE_ACK;
                end
            end
            ST_READ_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d  = rd_mux;
                    rvalid_d = 1'b1;
                    state_d  = ST_READ_VALID;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_READ_VALID: begin
                if (i_read_ack || !i_read_enable) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE_ACK: begin
                wr_en   = is_ctrl;
                state_d = ST_WRITE_RELEASE;
                if (is_ctrl) begin
                    written_d = 1'b1;
                    waddr_d   = addr_q;
                end
            end
            ST_WRITE_RELEASE: begin
                if (!i_write_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchronous reset wins over any in-flight commit.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state_q            <= ST_IDLE;
            lat_q              <= '0;
            addr_q             <= '0;
            o_register_data    <= 8'h00;
            o_read_valid       <= 1'b0;
            o_write_ack        <= 1'b0;
            o_reg_written      <= 1'b0;
            o_reg_written_addr <= 8'h00;
            for (int k = 0; k < NUM_STATUS; k++) status_q[k] <= 8'h00;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (k == 0)                     regs_q[k] <= DEVICE_ID;
                else if (k >= int'(STATUS_BASE)) regs_q[k] <= 8'h00;
                else                            regs_q[k] <= CTRL_RESET;
            end
        end else begin
            state_q            <= state_d;
            lat_q              <= lat_d;
            addr_q             <= addr_d;
            o_register_data    <= rdata_d;
            o_read_valid       <= rvalid_d;
            o_write_ack        <= wack_d;
            o_reg_written      <= written_d;
            o_reg_written_addr <= waddr_d;
            if (snap_en) begin
                for (int k = 0; k < NUM_STATUS; k++) status_q[k] <= i_status_regs[k*8 +: 8];
            end
            if (wr_en) regs_q[IDX_W'(addr_q)] <= i_register_data;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl_out
        assign o_ctrl_regs[k*8 +: 8] = regs_q[k];
    end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed bench for i2c_register_bank: vector table plus handshake corner cases.
module tb_i2c_register_bank;

    localparam int unsigned NREG  = 16;
    localparam int unsigned NSTAT = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned LAT4  = 4;
    localparam logic [7:0]  DEV   = 8'hA5;
    localparam logic [7:0]  CRST  = 8'h0F;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         addr_in = 8'h00;
    logic               en = 1'b0;
    logic               ack = 1'b0;
    logic [7:0]         wdata = 8'h00;
    logic               wv = 1'b0;
    logic [8*NSTAT-1:0] status = '0;

    logic [7:0]         rdata, waddr;
    logic               rvalid, wack, written;
    logic [8*NREG-1:0]  ctrl;

    logic [7:0]         r4_data, waddr4;
    logic               r4_valid, wack4, written4;
    logic [8*NREG-1:0]  ctrl4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_ctrl;

    always #5 clk = ~clk;

    i2c_register_bank #(
        .NUM_REGS(NREG), .NUM_STATUS(NSTAT), .DEVICE_ID(DEV),
        .CTRL_RESET(CRST), .READ_LATENCY(LAT)
    ) u_dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_register_address(addr_in),
        .i_read_enable(en), .o_register_data(rdata), .o_read_valid(rvalid),
        .i_read_ack(ack), .i_register_data(wdata), .i_write_valid(wv),
        .o_write_ack(wack), .o_ctrl_regs(ctrl), .i_status_regs(status),
        .o_reg_written(written), .o_reg_written_addr(waddr)
    );

    i2c_register_bank #(
        .NUM_REGS(NREG), .NUM_STATUS(NSTAT), .DEVICE_ID(DEV),
        .CTRL_RESET(CRST), .READ_LATENCY(LAT4)
    ) u_dut4 (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_register_address(addr_in),
        .i_read_enable(en), .o_register_data(r4_data), .o_read_valid(r4_valid),
        .i_read_ack(ack), .i_register_data(wdata), .i_write_valid(wv),
        .o_write_ack(wack4), .o_ctrl_regs(ctrl4), .i_status_regs(status),
        .o_reg_written(written4), .o_reg_written_addr(waddr4)
    );

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        bit         exp_wr;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] reset_vec();
        logic [127:0] v;
        for (int k = 0; k < int'(NREG); k++) begin
            if (k == 0)                     v[k*8 +: 8] = DEV;
            else if (k >= int'(NREG - NSTAT)) v[k*8 +: 8] = 8'h00;
            else                            v[k*8 +: 8] = CRST;
        end
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; ack = 1'b0; wv = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_ctrl = reset_vec();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        int n;
        bit seen;
        n = 0; seen = 0;
        addr_in = a; en = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (rvalid) begin seen = 1; n = i; end
        end
        check({name, " latency"}, 128'(n), 128'(LAT + 1));
        check({name, " data"}, rdata, exp);
        tick();
        check({name, " hold"}, {rvalid, rdata}, {1'b1, exp});
        ack = 1'b1;
        tick();
        check({name, " release"}, rvalid, 1'b0);
        ack = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit exp_wr,
                            input string name);
        addr_in = a; wdata = d; wv = 1'b1;
        tick();
        check({name, " ack"}, {wack, written}, {1'b1, 1'b0});
        check({name, " ctrl before"}, ctrl, exp_ctrl);
        if (exp_wr) exp_ctrl[int'(a)*8 +: 8] = d;
        tick();
        check({name, " ack pulse"}, wack, 1'b0);
        check({name, " written"}, written, exp_wr);
        if (exp_wr) check({name, " written addr"}, waddr, a);
        check({name, " ctrl after"}, ctrl, exp_ctrl);
        wv = 1'b0;
        tick();
        check({name, " no rewrite"}, {wack, written}, 2'b00);
        tick();
    endtask

    initial begin
        int n, rv_cycle, ack_cycle, ack_cnt, wr_cnt;
        bit seen;
        logic [7:0] rd_cap;

        // is_wr, addr, data, exp_rd, exp_wr
        vecs[0]  = '{1'b1, 8'h05, 8'h3C, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 8'h05, 8'h00, 8'h3C, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, 8'h77, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h0D, 8'h77, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 8'h40, 8'h77, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'h40, 8'h00, 8'hFF, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
        vecs[7]  = '{1'b1, 8'h01, 8'h81, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 8'h0B, 8'hEE, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 8'h0C, 8'h55, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'h0B, 8'h00, 8'hEE, 1'b0};
        vecs[11] = '{1'b0, 8'h01, 8'h00, 8'h81, 1'b0};
        vecs[12] = '{1'b0, 8'h0C, 8'h00, 8'h90, 1'b0};
        vecs[13] = '{1'b0, 8'h0F, 8'h00, 8'hC3, 1'b0};
        vecs[14] = '{1'b0, 8'h10, 8'h00, 8'hFF, 1'b0};
        vecs[15] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[16] = '{1'b0, 8'h02, 8'h00, 8'h0F, 1'b0};

        // Reset state
        do_reset();
        check("reset flags", {rvalid, wack, written}, 3'b000);
        check("reset rdata", rdata, 8'h00);
        check("reset waddr", waddr, 8'h00);
        check("reset ctrl", ctrl, exp_ctrl);

        // Read device ID: valid two cycles after enable, held until ack
        addr_in = 8'h00; en = 1'b1;
        tick();
        check("id read wait", rvalid, 1'b0);
        tick();
        check("id read valid", {rvalid, rdata}, {1'b1, 8'hA5});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("id read held", {rvalid, rdata}, {1'b1, 8'hA5});
        end
        ack = 1'b1;
        tick();
        check("id read ack drop", rvalid, 1'b0);
        ack = 1'b0; en = 1'b0;
        tick();

        // Vector table
        status = 32'hC3B2_A190;
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_wr, $sformatf("vec%0d wr", i));
            else
                do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d rd", i));
        end

        // Simultaneous read and write with a level-held write valid
        addr_in = 8'h03; wdata = 8'h99; en = 1'b1; wv = 1'b1;
        seen = 0; rv_cycle = -1; ack_cycle = -1; ack_cnt = 0; wr_cnt = 0; rd_cap = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rvalid && !seen) begin
                seen = 1; rv_cycle = i; rd_cap = rdata; ack = 1'b1;
            end else if (ack) begin
                ack = 1'b0; en = 1'b0;
            end
            if (wack) begin
                ack_cnt++;
                if (ack_cycle < 0) ack_cycle = i;
            end
            if (written) wr_cnt++;
            if (i == 9) wv = 1'b0;
        end
        exp_ctrl[3*8 +: 8] = 8'h99;
        check("rw read served", seen, 1'b1);
        check("rw read data", rd_cap, 8'h0F);
        check("rw ack count", 128'(ack_cnt), 128'd1);
        check("rw write count", 128'(wr_cnt), 128'd1);
        check("rw read first", (ack_cycle > rv_cycle), 1'b1);
        check("rw ctrl", ctrl, exp_ctrl);

        // Status snapshot taken at request time (latency 4 instance)
        do_reset();
        status = 32'h0000_1200;
        addr_in = 8'h0D; en = 1'b1;
        tick();
        status = 32'h0000_3400;
        seen = 0; n = 0;
        for (int i = 2; i <= 40 && !seen; i++) begin
            tick();
            if (r4_valid) begin seen = 1; n = i; end
        end
        check("snap latency", 128'(n), 128'(LAT4 + 1));
        check("snap data lat4", r4_data, 8'h12);
        check("snap data lat1", rdata, 8'h12);
        ack = 1'b1;
        tick();
        check("snap release", {r4_valid, rvalid}, 2'b00);
        ack = 1'b0; en = 1'b0;
        tick();
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (r4_valid) seen = 1;
        end
        check("snap fresh data", {r4_valid, r4_data}, {1'b1, 8'h34});
        ack = 1'b1;
        tick();
        ack = 1'b0; en = 1'b0;
        tick();

        // Reset during READ_VALID
        do_write(8'h07, 8'h42, 1'b1, "pre-reset wr");
        addr_in = 8'h00; en = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (rvalid) seen = 1;
        end
        check("rst rd reached valid", {rvalid, rdata}, {1'b1, 8'hA5});
        rst_n = 1'b0; en = 1'b0;
        tick();
        check("rst rd valid", rvalid, 1'b0);
        check("rst rd data", rdata, 8'h00);
        check("rst rd waddr", waddr, 8'h00);
        rst_n = 1'b1;
        tick();
        exp_ctrl = reset_vec();

        // Reset during WRITE_ACK: nothing committed
        addr_in = 8'h05; wdata = 8'h5A; wv = 1'b1;
        tick();
        check("rst wr in ack", wack, 1'b1);
        rst_n = 1'b0; wv = 1'b0;
        tick();
        check("rst wr flags", {wack, written}, 2'b00);
        check("rst wr ctrl", ctrl, exp_ctrl);
        rst_n = 1'b1;
        tick();
        check("rst wr no late commit", {written, ctrl}, {1'b0, exp_ctrl});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
